// File: rtl/ext_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ext_bus_sequencer
//  Purpose  : Turns single CPU memory cycles (11-bit address, 8-bit data,
//             rnw) into a multiplexed external bus. The high address bits and
//             the control strobes go out on pad_out. The low address and the
//             data share the bidirectional uio pins. The strobe can be
//             stretched by an external wait line, and a timeout guard aborts
//             the access if that line never releases.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WAIT_CYCLES   minimum strobe (oe_n/we_n low) length in cycles, 1..15
//    MAX_WAIT      extra cycles ext_wait may add before abort, 1..255
//  Ports
//    clk           clock, all logic on the rising edge
//    rst           synchronous reset, active high
//    req           CPU access request, sampled only while idle
//    rnw           1 = read, 0 = write (latched with req)
//    addr[10:0]    CPU address (latched with req)
//    wdata[7:0]    write data (latched with req)
//    ready         one-cycle completion pulse
//    rdata[7:0]    read data, valid with ready, held until next read
//    err           access aborted on timeout, held until next completion
//    ext_wait      external wait request, active high
//    pad_out[7:0]  {0, busy, we_n, oe_n, ale, addr[10:8]}
//    pad_io_in     uio input path
//    pad_io_out    uio output path (low address, then write data)
//    pad_io_oe     uio output enable, all bits equal, 1 = drive
// ============================================================================
module ext_bus_sequencer #(
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_WAIT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rnw,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic [7:0]  rdata,
    output logic        err,
    input  logic        ext_wait,
    output logic [7:0]  pad_out,
    input  logic [7:0]  pad_io_in,
    output logic [7:0]  pad_io_out,
    output logic [7:0]  pad_io_oe
);

    // Terminal values of the two access counters.
    localparam logic [3:0] c_base_last = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] c_max_wait  = 8'(MAX_WAIT);
    localparam logic [7:0] c_abort_rd  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALE    = 3'd1,
        S_TURN   = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;

    // Latched request.
    logic        r_rnw;
    logic [7:0]  r_wdata;
    logic [2:0]  r_addr_hi;

    // Registered pad-facing signals.
    logic        r_ale;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_busy;
    logic [7:0]  r_io_out;
    logic        r_io_oe;

    // Registered CPU-facing signals.
    logic        r_ready;
    logic [7:0]  r_rdata;
    logic        r_err;

    // r_base_cnt counts the guaranteed strobe cycles. r_wait_cnt counts the
    // cycles added by ext_wait once the base time has elapsed.
    logic [3:0]  r_base_cnt;
    logic [7:0]  r_wait_cnt;

    logic        w_base_done;
    logic        w_timeout;

    // Both decode registered counters only, so no input reaches an output
    // without passing through a flop.
    assign w_base_done = (r_base_cnt == c_base_last);
    assign w_timeout   = (r_wait_cnt == c_max_wait);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rnw      <= 1'b0;
            r_wdata    <= 8'h00;
            r_addr_hi  <= 3'd0;
            r_ale      <= 1'b0;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_io_out   <= 8'h00;
            r_io_oe    <= 1'b0;
            r_ready    <= 1'b0;
            r_rdata    <= 8'h00;
            r_err      <= 1'b0;
            r_base_cnt <= 4'd0;
            r_wait_cnt <= 8'd0;
        end else begin
            // ready is a single-cycle pulse. It is raised only on the edge
            // that enters DONE.
            r_ready <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    r_ale  <= 1'b0;
                    if (req) begin
                        r_rnw     <= rnw;
                        r_wdata   <= wdata;
                        r_addr_hi <= addr[10:8];
                        r_io_out  <= addr[7:0];
                        r_io_oe   <= 1'b1;
                        r_ale     <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ALE;
                    end
                end

                S_ALE: begin
                    // Drop ale and prepare the data phase. A read releases the
                    // bus one full cycle before oe_n falls, so the memory never
                    // drives against the address still on the pins.
                    r_ale      <= 1'b0;
                    r_base_cnt <= 4'd0;
                    r_wait_cnt <= 8'd0;
                    if (r_rnw) begin
                        r_io_oe <= 1'b0;
                    end else begin
                        r_io_oe  <= 1'b1;
                        r_io_out <= r_wdata;
                    end
                    r_state <= S_TURN;
                end

                S_TURN: begin
                    r_oe_n  <= ~r_rnw;
                    r_we_n  <= r_rnw;
                    r_state <= S_ACCESS;
                end

                S_ACCESS: begin
                    if (!w_base_done) begin
                        r_base_cnt <= r_base_cnt + 4'd1;
                    end else if (!ext_wait) begin
                        // Normal completion. Read data is sampled on the edge
                        // that closes the last strobe cycle.
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ready <= 1'b1;
                        r_err   <= 1'b0;
                        if (r_rnw) begin
                            r_rdata <= pad_io_in;
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        // Already stretched by MAX_WAIT cycles and still held
                        // off: abort. A read returns all ones.
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                        if (r_rnw) begin
                            r_rdata <= c_abort_rd;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                S_DONE: begin
                    // The write data has been held for one cycle after we_n
                    // rose. Release the bus and return to idle. A pending req
                    // is accepted on the next edge, so accesses are never
                    // back-to-back.
                    r_busy  <= 1'b0;
                    r_io_oe <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign rdata      = r_rdata;
    assign err        = r_err;
    assign pad_out    = {1'b0, r_busy, r_we_n, r_oe_n, r_ale, r_addr_hi};
    assign pad_io_out = r_io_out;
    assign pad_io_oe  = {8{r_io_oe}};

endmodule
`default_nettype wire
